fifo_wr_ctrl: RTL

//   Write-side controller for the FIFO IP demo. It sits directly upstream of the FIFO and

---
 rtl/fifo_wr_if.sv | 11 +
 rtl/fifo_wr_ctrl.sv | 53 +++++
 2 files changed

// File: rtl/fifo_wr_if.sv
// fifo_wr_if: write-port handshake between the burst controller and the FIFO
interface fifo_wr_if #(parameter int DW = 8);
  logic          wr_rst_busy;
  logic          empty;
  logic          almost_full;
  logic          full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  modport master (input wr_rst_busy, empty, almost_full, full, output fifo_wr_en, fifo_wr_data);
  modport slave  (output wr_rst_busy, empty, almost_full, full, input fifo_wr_en, fifo_wr_data);
endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: writes a burst of incrementing data each time the FIFO is seen to drain empty
module fifo_wr_ctrl #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             wr_clk,
  input  logic             rst,
  fifo_wr_if.master        bus,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             overflow_err
);
  typedef enum logic [1:0] {IDLE, FILL, WAIT_NE} state_t;
  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   empty_s, wr_en_q, wr_en_d, last;
  assign empty_s        = sync_q[SYNC_STAGES-1];
  assign bus.fifo_wr_en = wr_en_q & ~bus.wr_rst_busy;
  assign last           = bus.fifo_wr_en & (bus.almost_full | bus.full);
  // WAIT_NE must see empty_s drop before re-arming, so a stale empty cannot refill
  always_comb begin
    state_d = state;
    wr_en_d = wr_en_q;
    if (bus.wr_rst_busy) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
    end else begin
      case (state)
        IDLE:    if (empty_s) begin state_d = FILL; wr_en_d = 1'b1; end
        FILL:    if (last) begin state_d = WAIT_NE; wr_en_d = 1'b0; end
        WAIT_NE: begin wr_en_d = 1'b0; state_d = empty_s ? WAIT_NE : IDLE; end
        default: begin state_d = IDLE; wr_en_d = 1'b0; end
      endcase
    end
  end
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state            <= IDLE;
      sync_q           <= '0;
      wr_en_q          <= 1'b0;
      bus.fifo_wr_data <= '0;
      burst_cnt        <= '0;
      overflow_err     <= 1'b0;
    end else begin
      state   <= state_d;
      wr_en_q <= wr_en_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.empty};
      if (bus.fifo_wr_en) bus.fifo_wr_data <= bus.fifo_wr_data + 1'b1;
      if (state == FILL && last && burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
      if (bus.fifo_wr_en && bus.full) overflow_err <= 1'b1;
    end
  end
endmodule
